// File: rtl/global_params.sv
// rtl/global_params.sv - mesh-wide sizing constants shared by the NoC blocks
package global_params;
   localparam int MESH_SIDE = 4;
   localparam int DATA_W    = 8;
endpackage

// File: rtl/local_ni_if.sv
// rtl/local_ni_if.sv - core/router handshake bundle of the local network interface
// slave is the NI's own view; master is the view of whatever surrounds it.
interface local_ni_if #(
   parameter int COORD_W = 2,
   parameter int DATA_W  = 8
);
   localparam int DELTA_W = COORD_W + 1;

   logic               inj_valid;
   logic               inj_ready;
   logic [COORD_W-1:0] inj_dest_x;
   logic [COORD_W-1:0] inj_dest_y;
   logic [DATA_W-1:0]  inj_data;
   logic               inj_drop;

   logic               net_out_valid;
   logic               net_out_ready;
   logic [COORD_W-1:0] net_out_dest_x;
   logic [COORD_W-1:0] net_out_dest_y;
   logic [DELTA_W-1:0] net_out_s_delta_x;
   logic [DELTA_W-1:0] net_out_s_delta_y;
   logic [DATA_W-1:0]  net_out_data;

   logic               net_in_valid;
   logic               net_in_ready;
   logic [COORD_W-1:0] net_in_dest_x;
   logic [COORD_W-1:0] net_in_dest_y;
   logic [DATA_W-1:0]  net_in_data;

   logic               ej_valid;
   logic               ej_ready;
   logic [DATA_W-1:0]  ej_data;

   logic               dest_err;

   modport slave (
      input  inj_valid, inj_dest_x, inj_dest_y, inj_data, net_out_ready,
             net_in_valid, net_in_dest_x, net_in_dest_y, net_in_data, ej_ready,
      output inj_ready, inj_drop, net_out_valid, net_out_dest_x, net_out_dest_y,
             net_out_s_delta_x, net_out_s_delta_y, net_out_data, net_in_ready,
             ej_valid, ej_data, dest_err
   );

   modport master (
      output inj_valid, inj_dest_x, inj_dest_y, inj_data, net_out_ready,
             net_in_valid, net_in_dest_x, net_in_dest_y, net_in_data, ej_ready,
      input  inj_ready, inj_drop, net_out_valid, net_out_dest_x, net_out_dest_y,
             net_out_s_delta_x, net_out_s_delta_y, net_out_data, net_in_ready,
             ej_valid, ej_data, dest_err
   );
endinterface

// File: rtl/local_ni.sv
// rtl/local_ni.sv - mesh local network interface: TX/RX FIFOs between core and router LOCAL port
// Optional LOCAL_NI_DEST_CHECK_EN: drop misaddressed net_in packets and raise sticky dest_err.
module local_ni #(
   parameter int X_COORD    = 0,
   parameter int Y_COORD    = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int MESH_SIDE  = global_params::MESH_SIDE,
   parameter int DATA_W     = global_params::DATA_W
) (
   input  logic       clk,
   input  logic       rst,
   local_ni_if.slave  bus
);
   localparam int COORD_W = $clog2(MESH_SIDE);
   localparam int DELTA_W = COORD_W + 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int TX_W    = 2 * COORD_W + 2 * DELTA_W + DATA_W;

   localparam logic [COORD_W-1:0] X_LOC     = COORD_W'(X_COORD);
   localparam logic [COORD_W-1:0] Y_LOC     = COORD_W'(Y_COORD);
   localparam logic [DELTA_W-1:0] X_WIDE    = DELTA_W'(X_COORD);
   localparam logic [DELTA_W-1:0] Y_WIDE    = DELTA_W'(Y_COORD);
   localparam logic [DELTA_W-1:0] MESH_LIM  = DELTA_W'(MESH_SIDE);
   localparam logic [PTR_W:0]     DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic                ready_q;
   logic                drop_q, drop_d;
   logic [PTR_W-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PTR_W:0]      tx_cnt_q, tx_cnt_d;
   logic [PTR_W-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [PTR_W:0]      rx_cnt_q, rx_cnt_d;
   logic [TX_W-1:0]     tx_mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   rx_mem_q [FIFO_DEPTH];

   logic                tx_valid, tx_full, rx_valid, rx_full;
   logic                inj_acc, inj_bad, tx_push, tx_pop;
   logic                rx_acc, rx_mis, rx_push, rx_pop;
   logic [DELTA_W-1:0]  sdx, sdy;
   logic [TX_W-1:0]     tx_head;

   assign tx_valid = (tx_cnt_q != '0);
   assign tx_full  = (tx_cnt_q == DEPTH_CNT);
   assign rx_valid = (rx_cnt_q != '0);
   assign rx_full  = (rx_cnt_q == DEPTH_CNT);

   // ready_q holds both ready outputs low through reset without touching the FIFO state
   assign bus.inj_ready    = ready_q & ~tx_full;
   assign bus.net_in_ready = ready_q & ~rx_full;
   assign bus.inj_drop     = drop_q;

   assign sdx = {1'b0, bus.inj_dest_x} - X_WIDE;
   assign sdy = {1'b0, bus.inj_dest_y} - Y_WIDE;

   always_comb begin
      inj_acc  = bus.inj_valid & bus.inj_ready;
      inj_bad  = ((bus.inj_dest_x == X_LOC) && (bus.inj_dest_y == Y_LOC))
               || ({1'b0, bus.inj_dest_x} >= MESH_LIM)
               || ({1'b0, bus.inj_dest_y} >= MESH_LIM);
      tx_push  = inj_acc & ~inj_bad;
      tx_pop   = tx_valid & bus.net_out_ready;
      drop_d   = inj_acc & inj_bad;
      tx_wr_d  = tx_wr_q + PTR_W'(tx_push);
      tx_rd_d  = tx_rd_q + PTR_W'(tx_pop);
      tx_cnt_d = tx_cnt_q + (PTR_W + 1)'(tx_push) - (PTR_W + 1)'(tx_pop);

      rx_acc   = bus.net_in_valid & bus.net_in_ready;
      rx_push  = rx_acc & ~rx_mis;
      rx_pop   = rx_valid & bus.ej_ready;
      rx_wr_d  = rx_wr_q + PTR_W'(rx_push);
      rx_rd_d  = rx_rd_q + PTR_W'(rx_pop);
      rx_cnt_d = rx_cnt_q + (PTR_W + 1)'(rx_push) - (PTR_W + 1)'(rx_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ready_q  <= 1'b0;
         drop_q   <= 1'b0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         ready_q  <= 1'b1;
         drop_q   <= drop_d;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem_q[tx_wr_q] <= {bus.inj_dest_x, bus.inj_dest_y, sdx, sdy, bus.inj_data};
      end
      if (rx_push) begin
         rx_mem_q[rx_wr_q] <= bus.net_in_data;
      end
   end

   // Empty FIFOs present zeros so nothing stale leaks out after a reset
   assign tx_head = tx_valid ? tx_mem_q[tx_rd_q] : '0;
   assign bus.net_out_valid = tx_valid;
   assign {bus.net_out_dest_x, bus.net_out_dest_y,
           bus.net_out_s_delta_x, bus.net_out_s_delta_y, bus.net_out_data} = tx_head;

   assign bus.ej_valid = rx_valid;
   assign bus.ej_data  = rx_valid ? rx_mem_q[rx_rd_q] : '0;

`ifdef LOCAL_NI_DEST_CHECK_EN
   logic err_q;

   assign rx_mis = (bus.net_in_dest_x != X_LOC) || (bus.net_in_dest_y != Y_LOC);

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (rx_acc && rx_mis) begin
         err_q <= 1'b1;
      end
   end

   assign bus.dest_err = err_q;
`else
   assign rx_mis       = 1'b0;
   assign bus.dest_err = 1'b0;
`endif
endmodule

// File: tb/tb_local_ni.sv
// tb/tb_local_ni.sv - directed scoreboard bench for local_ni at X=1, Y=2 (plus a MESH_SIDE=3 instance)
module tb_local_ni;
   localparam int X = 1;
   localparam int Y = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [17:0] tx_q [$];
   logic [7:0]  rx_q [$];
   logic [17:0] out_word;

   local_ni_if #(.COORD_W(2), .DATA_W(8)) bus ();
   local_ni_if #(.COORD_W(2), .DATA_W(8)) bus3 ();

   local_ni #(.X_COORD(X), .Y_COORD(Y), .FIFO_DEPTH(4), .MESH_SIDE(4), .DATA_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   local_ni #(.X_COORD(X), .Y_COORD(Y), .FIFO_DEPTH(4), .MESH_SIDE(3), .DATA_W(8)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   always #5 clk = ~clk;

   assign out_word = {bus.net_out_dest_x, bus.net_out_dest_y,
                      bus.net_out_s_delta_x, bus.net_out_s_delta_y, bus.net_out_data};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] tx_word(input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [7:0] d);
      logic [2:0] sx, sy;
      sx = 3'(int'(dx) - X);
      sy = 3'(int'(dy) - Y);
      return {dx, dy, sx, sy, d};
   endfunction

   function automatic logic is_drop(input int dx, input int dy, input int ms);
      return ((dx == X) && (dy == Y)) || (dx >= ms) || (dy >= ms);
   endfunction

   task automatic pop_out(input string tag);
      logic [17:0] exp;
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 18'h3ffff;
      chk({tag, "_valid"}, bus.net_out_valid, 1);
      chk(tag, out_word, exp);
   endtask

   task automatic pop_ej(input string tag);
      logic [7:0] exp;
      exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      chk({tag, "_valid"}, bus.ej_valid, 1);
      chk(tag, bus.ej_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      bus.inj_valid = 0; bus.inj_dest_x = 0; bus.inj_dest_y = 0; bus.inj_data = 0;
      bus.net_out_ready = 0; bus.net_in_valid = 0; bus.net_in_dest_x = 0;
      bus.net_in_dest_y = 0; bus.net_in_data = 0; bus.ej_ready = 0;
      bus3.inj_valid = 0; bus3.inj_dest_x = 0; bus3.inj_dest_y = 0; bus3.inj_data = 0;
      bus3.net_out_ready = 0; bus3.net_in_valid = 0; bus3.net_in_dest_x = 0;
      bus3.net_in_dest_y = 0; bus3.net_in_data = 0; bus3.ej_ready = 0;

      // reset state
      rst = 0;
      step(); step();
      chk("rst_inj_ready", bus.inj_ready, 0);
      chk("rst_net_out_valid", bus.net_out_valid, 0);
      chk("rst_net_in_ready", bus.net_in_ready, 0);
      chk("rst_ej_valid", bus.ej_valid, 0);
      chk("rst_inj_drop", bus.inj_drop, 0);
      chk("rst_dest_err", bus.dest_err, 0);
      chk("rst_net_out_word", out_word, 0);
      chk("rst_ej_data", bus.ej_data, 0);
      rst = 1;
      step();
      chk("post_rst_inj_ready", bus.inj_ready, 1);
      chk("post_rst_net_in_ready", bus.net_in_ready, 1);

      // single injection, one-cycle latency, stall hold
      bus.inj_valid = 1; bus.inj_dest_x = 3; bus.inj_dest_y = 0; bus.inj_data = 8'hA5;
      tx_q.push_back(tx_word(2'd3, 2'd0, 8'hA5));
      step();
      bus.inj_valid = 0;
      chk("lat_valid", bus.net_out_valid, 1);
      chk("lat_sdx", bus.net_out_s_delta_x, 3'b010);
      chk("lat_sdy", bus.net_out_s_delta_y, 3'b110);
      chk("lat_data", bus.net_out_data, 8'hA5);
      step();
      bus.net_out_ready = 1;
      pop_out("stall_hold_word");
      step();
      chk("single_drained", bus.net_out_valid, 0);

      // fill TX FIFO with output stalled, then drain in order
      bus.net_out_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         chk("fill_inj_ready", bus.inj_ready, (i <= 4));
         if (i <= 4) tx_q.push_back(tx_word(2'd2, 2'd3, 8'(i)));
         bus.inj_valid = 1; bus.inj_dest_x = 2; bus.inj_dest_y = 3; bus.inj_data = 8'(i);
         step();
      end
      bus.inj_valid = 0;
      chk("full_inj_ready", bus.inj_ready, 0);
      bus.net_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         pop_out("tx_order");
         step();
      end
      chk("tx_empty_valid", bus.net_out_valid, 0);
      chk("tx_empty_ready", bus.inj_ready, 1);
      bus.net_out_ready = 0;

      // drops: self address on both instances, out-of-range on MESH_SIDE=3
      bus.inj_valid = 1; bus.inj_dest_x = 1; bus.inj_dest_y = 2; bus.inj_data = 8'h11;
      bus3.inj_valid = 1; bus3.inj_dest_x = 1; bus3.inj_dest_y = 2; bus3.inj_data = 8'h11;
      step();
      bus.inj_valid = 0;
      chk("drop_self", bus.inj_drop, is_drop(1, 2, 4));
      chk("drop_self_nv", bus.net_out_valid, 0);
      chk("drop3_self", bus3.inj_drop, is_drop(1, 2, 3));
      bus3.inj_dest_x = 3; bus3.inj_dest_y = 3;
      step();
      chk("drop_pulse_end", bus.inj_drop, 0);
      chk("drop3_range", bus3.inj_drop, is_drop(3, 3, 3));
      chk("drop3_range_nv", bus3.net_out_valid, 0);
      bus3.inj_dest_x = 2; bus3.inj_dest_y = 2; bus3.inj_data = 8'h33;
      step();
      bus3.inj_valid = 0;
      chk("drop3_edge_in_range", bus3.inj_drop, is_drop(2, 2, 3));
      chk("drop3_edge_valid", bus3.net_out_valid, 1);
      chk("drop3_edge_sdx", bus3.net_out_s_delta_x, 3'b001);
      chk("drop3_edge_sdy", bus3.net_out_s_delta_y, 3'b000);

      // RX fill with ejection stalled, then drain in order
      bus.ej_ready = 0;
      for (int i = 0; i < 4; i++) begin
         chk("rx_fill_ready", bus.net_in_ready, 1);
         bus.net_in_valid = 1; bus.net_in_dest_x = 1; bus.net_in_dest_y = 2;
         bus.net_in_data = 8'(8'h10 + i);
         rx_q.push_back(8'(8'h10 + i));
         step();
      end
      bus.net_in_valid = 0;
      chk("rx_full_ready", bus.net_in_ready, 0);
      pop_ej("rx_order_first");
      bus.ej_ready = 1;
      step();
      chk("rx_ready_after_pop", bus.net_in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         pop_ej("rx_order");
         step();
      end
      chk("rx_empty_valid", bus.ej_valid, 0);
      bus.ej_ready = 0;

      // reset with 2 TX and 3 RX entries in flight
      for (int i = 0; i < 3; i++) begin
         bus.inj_valid = (i < 2); bus.inj_dest_x = 0; bus.inj_dest_y = 1;
         bus.inj_data = 8'(8'h40 + i);
         bus.net_in_valid = 1; bus.net_in_dest_x = 1; bus.net_in_dest_y = 2;
         bus.net_in_data = 8'(8'h60 + i);
         step();
      end
      bus.inj_valid = 0; bus.net_in_valid = 0;
      chk("pre_rst_tx_valid", bus.net_out_valid, 1);
      chk("pre_rst_ej_valid", bus.ej_valid, 1);
      rst = 0;
      step();
      rst = 1;
      chk("mid_rst_net_out_valid", bus.net_out_valid, 0);
      chk("mid_rst_ej_valid", bus.ej_valid, 0);
      chk("mid_rst_word", out_word, 0);
      chk("mid_rst_ej_data", bus.ej_data, 0);
      chk("mid_rst_inj_ready", bus.inj_ready, 0);
      step();
      chk("after_rst_inj_ready", bus.inj_ready, 1);
      chk("after_rst_net_in_ready", bus.net_in_ready, 1);
      chk("after_rst_no_stale_tx", bus.net_out_valid, 0);
      chk("after_rst_no_stale_rx", bus.ej_valid, 0);
      bus.inj_valid = 1; bus.inj_dest_x = 0; bus.inj_dest_y = 3; bus.inj_data = 8'h77;
      bus.net_out_ready = 1;
      tx_q.push_back(tx_word(2'd0, 2'd3, 8'h77));
      step();
      bus.inj_valid = 0;
      pop_out("after_rst_fresh");
      step();
      chk("after_rst_drained", bus.net_out_valid, 0);
      bus.net_out_ready = 0;

      // misaddressed net_in packet
      bus.net_in_valid = 1; bus.net_in_dest_x = 0; bus.net_in_dest_y = 0;
      bus.net_in_data = 8'h55;
`ifdef LOCAL_NI_DEST_CHECK_EN
      chk("misdir_handshake", bus.net_in_ready, 1);
      step();
      bus.net_in_valid = 0;
      chk("misdir_ej_valid", bus.ej_valid, 0);
      chk("misdir_dest_err", bus.dest_err, 1);
      step(); step();
      chk("misdir_ej_still0", bus.ej_valid, 0);
      chk("misdir_err_sticky", bus.dest_err, 1);
      rst = 0;
      step();
      rst = 1;
      chk("misdir_err_cleared", bus.dest_err, 0);
      step();
`else
      rx_q.push_back(8'h55);
      step();
      bus.net_in_valid = 0;
      chk("nocheck_dest_err", bus.dest_err, 0);
      bus.ej_ready = 1;
      pop_ej("nocheck_deliver");
      step();
      bus.ej_ready = 0;
      chk("nocheck_drained", bus.ej_valid, 0);
      chk("nocheck_err_still0", bus.dest_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/local_ni.md
LOCAL_NI -- requirements
Module: local_ni

Interface
REQ-001 SHALL have parameter X_COORD, default 0: router column this interface serves.
REQ-002 SHALL have parameter Y_COORD, default 0: router row this interface serves.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries per TX/RX FIFO; power of 2, minimum 2.
REQ-004 SHALL use MESH_SIDE and DATA_W from global_params, with COORD_W = $clog2(MESH_SIDE) and DELTA_W = COORD_W+1.
REQ-005 SHALL have port clk, input, 1 bit: single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have ports inj_valid/inj_ready, in/out, 1 bit each: core injection handshake.
REQ-008 SHALL have ports inj_dest_x/inj_dest_y/inj_data, in, COORD_W/COORD_W/DATA_W: core packet.
REQ-009 SHALL have port inj_drop, out, 1 bit: one-cycle pulse when an accepted packet is discarded.
REQ-010 SHALL have ports net_out_valid/dest_x/dest_y/s_delta_x/s_delta_y/data, out, 1/COORD_W/COORD_W/DELTA_W/DELTA_W/DATA_W: drive the router LOCAL input.
REQ-011 SHALL have port net_out_ready, in, 1 bit: ready from the router LOCAL input.
REQ-012 SHALL have ports net_in_valid/dest_x/dest_y/data, in, and net_in_ready, out: consume the router LOCAL output.
REQ-013 SHALL have ports ej_valid/ej_data, out, 1/DATA_W, and ej_ready, in: core ejection handshake.
REQ-014 SHALL have port dest_err, out, 1 bit: sticky misdelivery flag (see Configuration).

Function
REQ-015 SHALL count a transfer on any valid/ready pair only in a cycle where both are 1 at the clk rising edge.
REQ-016 SHALL drive inj_ready = !tx_full, registered state only, with no combinational path from net_out_ready.
REQ-017 SHALL discard an accepted packet, without writing it to the TX FIFO, when dest equals (X_COORD,Y_COORD) or either coordinate is >= MESH_SIDE; inj_drop SHALL be 1 in the following cycle.
REQ-018 SHALL, for a stored packet, compute s_delta_x = dest_x - X_COORD and s_delta_y = dest_y - Y_COORD in DELTA_W two's complement, at enqueue.
REQ-019 SHALL present an injection accepted in cycle N on net_out_* in cycle N+1 when the TX FIFO was empty (1-cycle latency).
REQ-020 SHALL hold net_out_* stable while net_out_valid=1 and net_out_ready=0.
REQ-021 SHALL leave the TX count unchanged on a simultaneous push and pop; a push while full SHALL be impossible (inj_ready=0).
REQ-022 SHALL drive net_in_ready = !rx_full; an accepted packet SHALL appear on ej_* at N+1 when the RX FIFO was empty.
REQ-023 SHALL deliver packets in FIFO order in both directions; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 SHALL hold all outputs stable while ej_valid=1 and ej_ready=0.

Reset
REQ-025 SHALL, while rst=0 at a clk edge, clear both FIFO pointers and counts; inj_ready=0, net_out_valid=0, net_in_ready=0, ej_valid=0, inj_drop=0, dest_err=0; data outputs 0.
REQ-026 SHALL discard in-flight FIFO contents on reset mid-operation; inj_ready and net_in_ready SHALL be 1 in the first cycle after rst returns to 1.

Configuration
REQ-027 SHALL, when LOCAL_NI_DEST_CHECK_EN is defined, drop each net_in packet with (dest_x,dest_y) != (X_COORD,Y_COORD) (still handshaken, not written to RX) and set dest_err=1 until reset.
REQ-028 SHALL, when LOCAL_NI_DEST_CHECK_EN is undefined, accept every net_in packet, tie dest_err to 0 and not read net_in_dest_*.

Verification
REQ-029 SHALL cover, with MESH_SIDE=4, DATA_W=8, X=1, Y=2: inject (3,0,0xA5) -> next cycle net_out_valid=1, dest=(3,0), s_delta_x=+2, s_delta_y=-2, data=0xA5.
REQ-030 SHALL cover: net_out_ready=0, 5 injections with data 1..5 -> inj_ready=0 after the 4th; data 5 not accepted; release -> 1,2,3,4 in order.
REQ-031 SHALL cover: inject dest (1,2), then dest (3,3) with MESH_SIDE=3 -> inj_drop pulses twice; net_out_valid stays 0.
REQ-032 SHALL cover: ej_ready=0, 4 net_in packets -> net_in_ready=0; then ej_ready=1 -> 4 packets out in order; net_in_ready=1 one cycle after the first pop.
REQ-033 SHALL cover: rst=0 for one cycle with 2 TX and 3 RX entries -> next cycle net_out_valid=0, ej_valid=0, and no stale data afterwards.
REQ-034 SHALL cover, with LOCAL_NI_DEST_CHECK_EN defined: net_in packet dest (0,0) -> ej_valid stays 0 and dest_err=1 persists until reset.
